// File: rtl/teclado_pkg.sv
// rtl/teclado_pkg.sv - shared types and constants for the PS/2 keyboard front end
//
// Contents:
//   rx_state_t    receiver FSM states (IDLE, SHIFT, CHECK)
//   BREAK_CODE    PS/2 break prefix
//   DEF_ALARM     default scan code that raises the alarm
//   DEF_CLEAR     default scan code that clears the alarm
//   hex_to_seg()  hex nibble to active-low 7-segment pattern, dp off

package teclado_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] DEF_ALARM  = 8'h1C;
    localparam logic [7:0] DEF_CLEAR  = 8'h76;

    // Segment order is {dp, g, f, e, d, c, b, a}; a 0 lights the segment.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver with synchroniser, glitch filter, checking and timeout
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   ps2c, ps2d      raw PS/2 clock and data lines (asynchronous)
//   rx_en           allows new frames to start
//   data[7:0]       last valid scan code (held until next valid frame)
//   rx_done         one-cycle pulse when data is updated
//   frame_err       one-cycle pulse on parity/stop error or timeout

import teclado_pkg::*;

module ps2_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] data,
    output logic       rx_done,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [1:0]    c_sync;
    logic [1:0]    d_sync;
    logic          c_filt;
    logic [FW-1:0] flt_cnt;
    logic          fall;

    rx_state_t     state;
    logic [9:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] timer;

    // Lines idle high, so the synchronisers and filter reset to 1 to
    // avoid a spurious falling edge coming out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
        end else begin
            c_sync <= {c_sync[0], ps2c};
            d_sync <= {d_sync[0], ps2d};
        end
    end

    // A new ps2c level is accepted only after FILTER_LEN consecutive
    // samples disagree with the current filtered level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_filt  <= 1'b1;
            flt_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (c_sync[1] == c_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                c_filt  <= c_sync[1];
                flt_cnt <= '0;
                fall    <= ~c_sync[1];
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    // After 10 shifts: shreg[7:0] = data, shreg[8] = parity, shreg[9] = stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            timer     <= '0;
            data      <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (fall && rx_en && !d_sync[1]) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        shreg <= {d_sync[1], shreg[9:1]};
                        timer <= '0;
                        if (bit_cnt == 4'd9) begin
                            state <= CHECK;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else if (timer == TMO_LAST) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if ((^shreg[8:0]) && shreg[9]) begin
                        data    <= shreg[7:0];
                        rx_done <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/principal_teclado.sv
// rtl/principal_teclado.sv - PS/2 keyboard front end with LEDs, alarm and 4-digit hex display
//
// Ports:
//   clk          100 MHz system clock
//   reset        asynchronous active-low reset
//   ps2d, ps2c   PS/2 data and clock lines
//   rx_en        reception enable
//   Led1         stretched frame-received indicator
//   Led2         sticky frame-error indicator
//   Alarma2      alarm flag
//   sel_display  digit anodes, active-low
//   display      segments, active-low, [7]=dp

import teclado_pkg::*;

module principal_teclado #(
    parameter int         FILTER_LEN    = 8,
    parameter int         TIMEOUT_CYC   = 2_000_000,
    parameter int         REFRESH_BITS  = 18,
    parameter int         LED_HOLD_BITS = 24,
    parameter logic [7:0] ALARM_CODE    = DEF_ALARM,
    parameter logic [7:0] CLEAR_CODE    = DEF_CLEAR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    input  logic       rx_en,
    output logic       Led1,
    output logic       Led2,
    output logic       Alarma2,
    output logic [3:0] sel_display,
    output logic [7:0] display
);

    logic [7:0]               rx_data;
    logic                     rx_done;
    logic                     frame_err;
    logic [7:0]               last_code;
    logic [7:0]               prev_code;
    logic                     break_pending;
    logic [LED_HOLD_BITS-1:0] led_cnt;
    logic [REFRESH_BITS-1:0]  refresh;
    logic [3:0]               sel_next;
    logic [3:0]               nibble;

    ps2_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk),
        .rst_n     (reset),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .rx_en     (rx_en),
        .data      (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err)
    );

    // The code right after a break prefix is a key release, so it is
    // stored for display but must not touch the alarm.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_code     <= 8'h00;
            prev_code     <= 8'h00;
            break_pending <= 1'b0;
            Alarma2       <= 1'b0;
            Led2          <= 1'b0;
        end else begin
            if (frame_err) begin
                Led2 <= 1'b1;
            end
            if (rx_done) begin
                prev_code <= last_code;
                last_code <= rx_data;
                if (rx_data == BREAK_CODE) begin
                    break_pending <= 1'b1;
                end else if (break_pending) begin
                    break_pending <= 1'b0;
                end else if (rx_data == ALARM_CODE) begin
                    Alarma2 <= 1'b1;
                end else if (rx_data == CLEAR_CODE) begin
                    Alarma2 <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_cnt <= '0;
        end else if (rx_done) begin
            led_cnt <= '1;
        end else if (led_cnt != '0) begin
            led_cnt <= led_cnt - 1'b1;
        end
    end

    assign Led1 = (led_cnt != '0);

    always_comb begin
        sel_next = 4'b1110;
        nibble   = last_code[3:0];
        case (refresh[REFRESH_BITS-1 -: 2])
            2'd0: begin sel_next = 4'b1110; nibble = last_code[3:0]; end
            2'd1: begin sel_next = 4'b1101; nibble = last_code[7:4]; end
            2'd2: begin sel_next = 4'b1011; nibble = prev_code[3:0]; end
            default: begin sel_next = 4'b0111; nibble = prev_code[7:4]; end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh     <= '0;
            sel_display <= 4'b1110;
            display     <= 8'hC0;
        end else begin
            refresh     <= refresh + 1'b1;
            sel_display <= sel_next;
            display     <= hex_to_seg(nibble);
        end
    end

endmodule

// File: tb/tb_principal_teclado.sv
// tb/tb_principal_teclado.sv - randomized self-checking bench for principal_teclado

module tb_principal_teclado;

    localparam int FILTER_LEN    = 4;
    localparam int TIMEOUT_CYC   = 3000;
    localparam int REFRESH_BITS  = 6;
    localparam int LED_HOLD_BITS = 10;
    localparam int HALF          = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2d = 1'b1;
    logic       ps2c = 1'b1;
    logic       rx_en = 1'b1;
    logic       Led1, Led2, Alarma2;
    logic [3:0] sel_display;
    logic [7:0] display;

    int vectors = 0;
    int errors  = 0;

    // Reference model: the two most recent accepted codes, alarm and error flags.
    logic [7:0] m_last, m_prev;
    logic       m_alarm, m_err;

    principal_teclado #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYC   (TIMEOUT_CYC),
        .REFRESH_BITS  (REFRESH_BITS),
        .LED_HOLD_BITS (LED_HOLD_BITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2d        (ps2d),
        .ps2c        (ps2c),
        .rx_en       (rx_en),
        .Led1        (Led1),
        .Led2        (Led2),
        .Alarma2     (Alarma2),
        .sel_display (sel_display),
        .display     (display)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        logic [7:0] t [16];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return t[n];
    endfunction

    // Expected display word {digit3, digit2, digit1, digit0}.
    function automatic logic [31:0] exp_digits();
        return {seg_of(m_prev[7:4]), seg_of(m_prev[3:0]),
                seg_of(m_last[7:4]), seg_of(m_last[3:0])};
    endfunction

    // A code is a key release (alarm-neutral) when the previously accepted code was F0.
    task automatic model_accept(input logic [7:0] code);
        if (m_last != 8'hF0) begin
            if (code == 8'h1C) m_alarm = 1'b1;
            if (code == 8'h76) m_alarm = 1'b0;
        end
        m_prev = m_last;
        m_last = code;
    endtask

    task automatic model_reset();
        m_last = 8'h00; m_prev = 8'h00; m_alarm = 1'b0; m_err = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1;
        #100;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (20) @(posedge clk);
    endtask

    // Collect all four digits by watching the anodes; bounded by two refresh sweeps.
    task automatic capture_digits(output logic [31:0] dig);
        logic [3:0] seen;
        dig  = 32'hxxxx_xxxx;
        seen = 4'b0000;
        for (int c = 0; c < (8 << (REFRESH_BITS - 2)) && seen != 4'hF; c++) begin
            @(negedge clk);
            case (sel_display)
                4'b1110: begin dig[7:0]   = display; seen[0] = 1'b1; end
                4'b1101: begin dig[15:8]  = display; seen[1] = 1'b1; end
                4'b1011: begin dig[23:16] = display; seen[2] = 1'b1; end
                4'b0111: begin dig[31:24] = display; seen[3] = 1'b1; end
                default: ;
            endcase
        end
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par,
                              input bit bad_stop, input int nbits, input int drop_en_at);
        logic [10:0] f;
        f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (i == drop_en_at) rx_en = 1'b0;
            ps2d = f[i];
            repeat (HALF / 2) @(posedge clk);
            ps2c = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2c = 1'b1;
            repeat (HALF / 2) @(posedge clk);
        end
        ps2d = 1'b1;
        repeat (40) @(posedge clk);
    endtask

    task automatic check_state(input string tag, input bit chk_led1);
        logic [31:0] dig;
        capture_digits(dig);
        vectors++;
        if (dig !== exp_digits()) begin
            errors++;
            $display("FAIL %s digits: got %h expected %h", tag, dig, exp_digits());
        end
        vectors++;
        if (Alarma2 !== m_alarm) begin
            errors++;
            $display("FAIL %s Alarma2: got %b expected %b", tag, Alarma2, m_alarm);
        end
        vectors++;
        if (Led2 !== m_err) begin
            errors++;
            $display("FAIL %s Led2: got %b expected %b", tag, Led2, m_err);
        end
        if (chk_led1) begin
            vectors++;
            if (Led1 !== 1'b1) begin
                errors++;
                $display("FAIL %s Led1: got %b expected 1", tag, Led1);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #30;
        vectors++;
        if (sel_display !== 4'b1110 || display !== 8'hC0) begin
            errors++;
            $display("FAIL reset_display: got sel=%b seg=%h expected sel=1110 seg=c0",
                     sel_display, display);
        end
        apply_reset();
        vectors++;
        if (Led1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_led1: got %b expected 0", Led1);
        end
        check_state("reset", 1'b0);
    endtask

    task automatic test_alarm();
        send_frame(8'h1C, 0, 0, 11, 99);
        model_accept(8'h1C);
        check_state("alarm_1c", 1'b1);
    endtask

    task automatic test_codes();
        send_frame(8'h76, 0, 0, 11, 99);
        model_accept(8'h76);
        check_state("clear_76", 1'b1);
        send_frame(8'h45, 0, 0, 11, 99);
        model_accept(8'h45);
        check_state("code_45", 1'b1);
    endtask

    task automatic test_break();
        send_frame(8'h1C, 0, 0, 11, 99);
        model_accept(8'h1C);
        send_frame(8'h76, 0, 0, 11, 99);
        model_accept(8'h76);
        send_frame(8'hF0, 0, 0, 11, 99);
        model_accept(8'hF0);
        check_state("break_f0", 1'b1);
        send_frame(8'h1C, 0, 0, 11, 99);
        model_accept(8'h1C);
        check_state("break_1c", 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] code;
        for (int n = 0; n < 12; n++) begin
            case ($urandom_range(0, 5))
                0:       code = 8'h1C;
                1:       code = 8'h76;
                2:       code = 8'hF0;
                default: code = 8'($urandom);
            endcase
            send_frame(code, 0, 0, 11, 99);
            model_accept(code);
            check_state("random", 1'b1);
        end
    endtask

    task automatic test_rx_enable();
        // Dropping rx_en mid-frame lets the frame finish.
        rx_en = 1'b1;
        send_frame(8'h33, 0, 0, 11, 3);
        model_accept(8'h33);
        check_state("en_drop_mid", 1'b1);
        // A whole frame with rx_en low is ignored.
        repeat (1100) @(posedge clk);
        rx_en = 1'b0;
        send_frame(8'h1C, 0, 0, 11, 99);
        check_state("en_low", 1'b0);
        vectors++;
        if (Led1 !== 1'b0) begin
            errors++;
            $display("FAIL en_low_led1: got %b expected 0", Led1);
        end
        rx_en = 1'b1;
    endtask

    task automatic test_timeout();
        apply_reset();
        send_frame(8'h5A, 0, 0, 5, 99);
        repeat (1000) @(posedge clk);
        check_state("timeout_before", 1'b0);
        repeat (2500) @(posedge clk);
        m_err = 1'b1;
        check_state("timeout_after", 1'b0);
        send_frame(8'h29, 0, 0, 11, 99);
        model_accept(8'h29);
        check_state("after_timeout_29", 1'b1);
    endtask

    task automatic test_bad_frames();
        apply_reset();
        send_frame(8'h5A, 0, 0, 11, 99);
        model_accept(8'h5A);
        check_state("pre_bad", 1'b1);
        send_frame(8'h11, 1, 0, 11, 99);
        m_err = 1'b1;
        check_state("bad_parity", 1'b0);
        send_frame(8'h22, 0, 1, 11, 99);
        check_state("bad_stop", 1'b0);
        send_frame(8'h1C, 0, 0, 11, 99);
        model_accept(8'h1C);
        check_state("after_bad", 1'b1);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alarm();
        test_codes();
        test_break();
        test_random();
        test_rx_enable();
        test_timeout();
        test_bad_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
